clock_alarm_ctrl: RTL and testbench
===================================

Name: clock_alarm_ctrl

Overview:
- Time-of-day and alarm controller that drives the VGA clock/alarm overlay.
- Keeps a 24-hour BCD time (HH:MM:SS) from an internal 1 Hz prescaler and holds a BCD alarm time.
- A 3-state mode machine handles time-set and alarm-set, driven by pre-debounced single-cycle button pulses.
- Feeds the overlay's 12 digit inputs and its settime highlight, and raises alarm_ring when time matches the armed alarm.

Parameters:
- TICK_DIV, 100_000_000: clk cycles per 1 s tick; minimum 2.
- RING_SECS, 30: seconds alarm_ring stays asserted unless dismissed; range 1..255.
- SNOOZE_SECS, 300: snooze delay in seconds; range 1..1023. Used only with SNOOZE_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn_mode  in  1  one-cycle pulse; advances the mode.
- btn_field  in  1  one-cycle pulse; advances the selected field.
- btn_inc  in  1  one-cycle pulse; increments the selected field, or dismisses/snoozes the alarm.
- alarm_arm  in  1  level; 1 enables alarm triggering.
- settime  out  1  1 in any set mode.
- mode  out  2  0=RUN, 1=SET_TIME, 2=SET_ALARM.
- field_sel  out  2  0=HOUR, 1=MIN, 2=SEC.
- hourMSB, hourLSB, minMSB, minLSB, secMSB, secLSB  out  4 each  current time, BCD.
- alarmhourMSB, alarmhourLSB, alarmminMSB, alarmminLSB, alarmsecMSB, alarmsecLSB  out  4 each  alarm time, BCD.
- alarm_ring  out  1  alarm active.

Behaviour:
- All outputs registered.
- Reset (async) values:
  - time 00:00:00, alarm 00:00:00, mode RUN, field_sel HOUR.
  - settime 0, alarm_ring 0, prescaler 0, ring/snooze counters 0.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick = (count == TICK_DIV-1), then wraps to 0.
  - Held at 0 while mode = SET_TIME. Free-runs in RUN and SET_ALARM.
- Time advance on tick (RUN or SET_ALARM):
  - Outputs update the clk edge after the tick cycle.
  - BCD carry: sec 59 -> 00 with carry to min; min 59 -> 00 with carry to hour; hour 23 -> 00.
  - 23:59:59 -> 00:00:00.
  - LSB digits wrap 9 -> 0 into the MSB; MSB digit never exceeds 5 for min/sec or 2 for hour; hour 19 -> 20.
- Mode FSM, on btn_mode: RUN -> SET_TIME -> SET_ALARM -> RUN.
  - Every mode change resets field_sel to HOUR.
  - settime = (mode != RUN).
- btn_field in set modes: HOUR -> MIN -> SEC -> HOUR. Ignored in RUN.
- btn_inc in SET_TIME / SET_ALARM:
  - Increments the selected field of time / alarm, mod 24 for hour or mod 60 for min/sec.
  - No carry into other fields.
  - In SET_TIME, incrementing SEC does not reset the prescaler (it is already held).
- Priority within a cycle: btn_mode > btn_field > btn_inc. Lower-priority pulses in the same cycle are dropped.
- Alarm trigger:
  - Fires on the time-advance update whose new time equals the alarm value, when alarm_arm = 1 and mode != SET_TIME.
  - alarm_ring rises on the same edge the matching time appears.
  - Ring counter loads RING_SECS and decrements per tick.
  - alarm_ring clears when the counter would reach 0 (ring lasts exactly RING_SECS ticks).
- Dismiss:
  - btn_inc in RUN while ringing clears alarm_ring next edge.
  - btn_inc in RUN while not ringing has no effect.
- alarm_arm = 0 clears alarm_ring and any pending snooze next edge.
- Entering SET_TIME or SET_ALARM clears alarm_ring.
- Time set via btn_inc equal to the alarm value does not trigger; only tick-driven advances trigger.
- Retrigger on the same match while already ringing restarts the ring counter.
- Reset mid-operation returns everything to reset values immediately.

Optional Feature:
- Macro: CLOCK_ALARM_SNOOZE_EN.
- Defined:
  - Dismiss via btn_inc loads a snooze counter with SNOOZE_SECS.
  - The counter decrements per tick. On reaching 0, alarm_ring re-asserts for RING_SECS.
  - Snooze repeats on each dismiss.
  - btn_field in RUN while ringing or snoozing cancels fully (ring off, snooze cleared).
- Not defined:
  - No snooze counter logic.
  - Dismiss is final; btn_field in RUN is ignored.

Test Plan:
- Reset, TICK_DIV=4, run 4 ticks -> time 00:00:04; settime 0; all alarm digits 0.
- In SET_TIME, set hour to 23, min to 59, sec to 58; return to RUN; run 2 ticks -> 23:59:59, then 00:00:00, with each update one cycle after its tick.
- Press btn_mode x2 -> SET_ALARM with settime 1; time keeps counting; inc MIN 60 times -> alarm minute wraps back to 00; field_sel cycles HOUR, MIN, SEC, HOUR.
- Alarm 00:00:10, alarm_arm 1, RING_SECS=3, run from 00:00:00 -> alarm_ring rises with 00:00:10 and falls with 00:00:13.
- While ringing: btn_inc -> ring 0 next edge. Repeat run: drop alarm_arm -> ring 0. Repeat run: btn_mode -> ring 0, mode SET_TIME.
- btn_mode + btn_inc in the same cycle in SET_TIME -> mode SET_ALARM, time unchanged. With CLOCK_ALARM_SNOOZE_EN and SNOOZE_SECS=2: dismiss -> ring re-asserts 2 ticks later.

Source files
------------

// File: rtl/clock_alarm_ctrl.sv
// Time-of-day and alarm controller feeding the VGA clock/alarm overlay (BCD time, BCD alarm, set modes).
// Optional snooze support is compiled in when CLOCK_ALARM_SNOOZE_EN is defined.
module clock_alarm_ctrl #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int RING_SECS = 30
`ifdef CLOCK_ALARM_SNOOZE_EN
  , parameter int SNOOZE_SECS = 300
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_field,
  input  logic       btn_inc,
  input  logic       alarm_arm,
  output logic       settime,
  output logic [1:0] mode,
  output logic [1:0] field_sel,
  output logic [3:0] hourMSB,
  output logic [3:0] hourLSB,
  output logic [3:0] minMSB,
  output logic [3:0] minLSB,
  output logic [3:0] secMSB,
  output logic [3:0] secLSB,
  output logic [3:0] alarmhourMSB,
  output logic [3:0] alarmhourLSB,
  output logic [3:0] alarmminMSB,
  output logic [3:0] alarmminLSB,
  output logic [3:0] alarmsecMSB,
  output logic [3:0] alarmsecLSB,
  output logic       alarm_ring
);
  typedef enum logic [1:0] {RUN = 2'd0, SET_TIME = 2'd1, SET_ALARM = 2'd2} mode_t;
  typedef enum logic [1:0] {HOUR = 2'd0, MIN = 2'd1, SEC = 2'd2} field_t;

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0] RING_LOAD = 8'(RING_SECS);

  mode_t         mode_r;
  field_t        field_r;
  logic [PW-1:0] presc_r;
  logic [7:0]    hour_r, min_r, sec_r;
  logic [7:0]    al_hour_r, al_min_r, al_sec_r;
  logic [7:0]    hour_nx, min_nx, sec_nx;
  logic [7:0]    ring_cnt_r, ring_cnt_nx;
  logic          ring_r, ring_nx, settime_r;
  logic          tick_s, match_s, mode_ev, field_ev, inc_ev, enter_set_s, dismiss_s;
`ifdef CLOCK_ALARM_SNOOZE_EN
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SECS);
  logic [9:0]    snooze_r, snooze_nx;
  logic          cancel_s, snooze_fire_s;
`endif

  // Two-digit BCD increment that wraps to 00 after the given top value.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top) begin
      return 8'h00;
    end else if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  assign mode       = mode_r;
  assign field_sel  = field_r;
  assign settime    = settime_r;
  assign alarm_ring = ring_r;
  assign {hourMSB, hourLSB} = hour_r;
  assign {minMSB, minLSB}   = min_r;
  assign {secMSB, secLSB}   = sec_r;
  assign {alarmhourMSB, alarmhourLSB} = al_hour_r;
  assign {alarmminMSB, alarmminLSB}   = al_min_r;
  assign {alarmsecMSB, alarmsecLSB}   = al_sec_r;

  // Button priority decode, 1 s tick and the tick-driven next time with its alarm match.
  always_comb begin
    mode_ev     = btn_mode;
    field_ev    = btn_field & ~btn_mode;
    inc_ev      = btn_inc & ~btn_mode & ~btn_field;
    enter_set_s = mode_ev && (mode_r != SET_ALARM);
    dismiss_s   = inc_ev && (mode_r == RUN) && ring_r;
    tick_s      = (mode_r != SET_TIME) && (presc_r == TICK_LAST);
    sec_nx      = bcd_inc(sec_r, 8'h59);
    if (sec_r == 8'h59) begin
      min_nx = bcd_inc(min_r, 8'h59);
    end else begin
      min_nx = min_r;
    end
    if ((sec_r == 8'h59) && (min_r == 8'h59)) begin
      hour_nx = bcd_inc(hour_r, 8'h23);
    end else begin
      hour_nx = hour_r;
    end
    match_s = ({hour_nx, min_nx, sec_nx} == {al_hour_r, al_min_r, al_sec_r});
`ifdef CLOCK_ALARM_SNOOZE_EN
    cancel_s      = field_ev && (mode_r == RUN) && (ring_r || (snooze_r != 10'd0));
    snooze_fire_s = tick_s && (snooze_r == 10'd1);
`endif
  end

  // Ring state: clears outrank a new trigger, which outranks the countdown.
  always_comb begin
    ring_nx     = ring_r;
    ring_cnt_nx = ring_cnt_r;
    if (!alarm_arm || enter_set_s) begin
      ring_nx     = 1'b0;
      ring_cnt_nx = 8'd0;
`ifdef CLOCK_ALARM_SNOOZE_EN
    end else if (cancel_s) begin
      ring_nx     = 1'b0;
      ring_cnt_nx = 8'd0;
`endif
    end else if (dismiss_s) begin
      ring_nx     = 1'b0;
      ring_cnt_nx = 8'd0;
    end else if (tick_s && match_s) begin
      ring_nx     = 1'b1;
      ring_cnt_nx = RING_LOAD;
`ifdef CLOCK_ALARM_SNOOZE_EN
    end else if (snooze_fire_s) begin
      ring_nx     = 1'b1;
      ring_cnt_nx = RING_LOAD;
`endif
    end else if (tick_s && ring_r && (ring_cnt_r <= 8'd1)) begin
      ring_nx     = 1'b0;
      ring_cnt_nx = 8'd0;
    end else if (tick_s && ring_r) begin
      ring_nx     = 1'b1;
      ring_cnt_nx = ring_cnt_r - 8'd1;
    end else begin
      ring_nx     = ring_r;
      ring_cnt_nx = ring_cnt_r;
    end
  end

`ifdef CLOCK_ALARM_SNOOZE_EN
  // Snooze countdown: loaded on dismiss, wiped by disarm or cancel.
  always_comb begin
    snooze_nx = snooze_r;
    if (!alarm_arm || cancel_s) begin
      snooze_nx = 10'd0;
    end else if (dismiss_s) begin
      snooze_nx = SNOOZE_LOAD;
    end else if (tick_s && (snooze_r != 10'd0)) begin
      snooze_nx = snooze_r - 10'd1;
    end else begin
      snooze_nx = snooze_r;
    end
  end
`endif

  // Prescaler, time and alarm registers, mode/field FSM and alarm outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_r    <= '0;
      hour_r     <= 8'h00;
      min_r      <= 8'h00;
      sec_r      <= 8'h00;
      al_hour_r  <= 8'h00;
      al_min_r   <= 8'h00;
      al_sec_r   <= 8'h00;
      mode_r     <= RUN;
      field_r    <= HOUR;
      settime_r  <= 1'b0;
      ring_r     <= 1'b0;
      ring_cnt_r <= 8'd0;
`ifdef CLOCK_ALARM_SNOOZE_EN
      snooze_r   <= 10'd0;
`endif
    end else begin
      if ((mode_r == SET_TIME) || tick_s) begin
        presc_r <= '0;
      end else begin
        presc_r <= presc_r + PW'(1);
      end

      // The tick never fires in SET_TIME, so it cannot collide with a time edit.
      if (tick_s) begin
        hour_r <= hour_nx;
        min_r  <= min_nx;
        sec_r  <= sec_nx;
      end else if (inc_ev && (mode_r == SET_TIME)) begin
        case (field_r)
          HOUR:    hour_r <= bcd_inc(hour_r, 8'h23);
          MIN:     min_r  <= bcd_inc(min_r, 8'h59);
          default: sec_r  <= bcd_inc(sec_r, 8'h59);
        endcase
      end

      if (inc_ev && (mode_r == SET_ALARM)) begin
        case (field_r)
          HOUR:    al_hour_r <= bcd_inc(al_hour_r, 8'h23);
          MIN:     al_min_r  <= bcd_inc(al_min_r, 8'h59);
          default: al_sec_r  <= bcd_inc(al_sec_r, 8'h59);
        endcase
      end

      if (mode_ev) begin
        field_r <= HOUR;
        case (mode_r)
          RUN:      begin mode_r <= SET_TIME;  settime_r <= 1'b1; end
          SET_TIME: begin mode_r <= SET_ALARM; settime_r <= 1'b1; end
          default:  begin mode_r <= RUN;       settime_r <= 1'b0; end
        endcase
      end else if (field_ev && (mode_r != RUN)) begin
        case (field_r)
          HOUR:    field_r <= MIN;
          MIN:     field_r <= SEC;
          default: field_r <= HOUR;
        endcase
      end

      ring_r     <= ring_nx;
      ring_cnt_r <= ring_cnt_nx;
`ifdef CLOCK_ALARM_SNOOZE_EN
      snooze_r   <= snooze_nx;
`endif
    end
  end
endmodule

// File: tb/tb_clock_alarm_ctrl.sv
// Scoreboard bench for clock_alarm_ctrl: a seconds-of-day reference model predicts each post-edge
// output set, a monitor compares the DUT one time unit after every rising edge.
module tb_clock_alarm_ctrl;
  localparam int TD = 4;
  localparam int RS = 3;
  localparam int SS = 2;

  logic clk, reset, btn_mode, btn_field, btn_inc, alarm_arm;
  logic settime, alarm_ring;
  logic [1:0] mode, field_sel;
  logic [3:0] hourMSB, hourLSB, minMSB, minLSB, secMSB, secLSB;
  logic [3:0] alarmhourMSB, alarmhourLSB, alarmminMSB, alarmminLSB, alarmsecMSB, alarmsecLSB;

  clock_alarm_ctrl #(
    .TICK_DIV(TD), .RING_SECS(RS)
`ifdef CLOCK_ALARM_SNOOZE_EN
    , .SNOOZE_SECS(SS)
`endif
  ) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_field(btn_field), .btn_inc(btn_inc),
    .alarm_arm(alarm_arm), .settime(settime), .mode(mode), .field_sel(field_sel),
    .hourMSB(hourMSB), .hourLSB(hourLSB), .minMSB(minMSB), .minLSB(minLSB),
    .secMSB(secMSB), .secLSB(secLSB),
    .alarmhourMSB(alarmhourMSB), .alarmhourLSB(alarmhourLSB), .alarmminMSB(alarmminMSB),
    .alarmminLSB(alarmminLSB), .alarmsecMSB(alarmsecMSB), .alarmsecLSB(alarmsecLSB),
    .alarm_ring(alarm_ring)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] tm;
    logic [23:0] al;
    logic [1:0]  md;
    logic [1:0]  fs;
    logic        st;
    logic        rg;
  } snap_t;

  snap_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int rings_seen = 0;
  bit arm = 1'b0;

  // Reference state: time and alarm as seconds of the day.
  int m_presc, m_t, m_al, m_mode, m_field, m_left, m_sn;
  bit m_ring;

  function automatic int bump(input int v, input int f);
    int h, m, s;
    h = v / 3600; m = (v / 60) % 60; s = v % 60;
    case (f)
      0:       h = (h + 1) % 24;
      1:       m = (m + 1) % 60;
      default: s = (s + 1) % 60;
    endcase
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic logic [23:0] to_bcd(input int v);
    int h, m, s;
    h = v / 3600; m = (v / 60) % 60; s = v % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic snap_t snap();
    snap_t e;
    e.tm = to_bcd(m_t);
    e.al = to_bcd(m_al);
    e.md = 2'(m_mode);
    e.fs = 2'(m_field);
    e.st = (m_mode != 0);
    e.rg = m_ring;
    return e;
  endfunction

  task automatic model_reset();
    m_presc = 0; m_t = 0; m_al = 0; m_mode = 0; m_field = 0; m_left = 0; m_sn = 0; m_ring = 1'b0;
  endtask

  task automatic model_step(input bit bm, input bit bf, input bit bi);
    bit tick, fe, ie, r;
    int t_tick, nmode, left, sn;
    tick   = (m_mode != 1) && (m_presc == TD - 1);
    fe     = bf && !bm;
    ie     = bi && !bm && !bf;
    t_tick = (m_t + 1) % 86400;
    nmode  = bm ? (m_mode + 1) % 3 : m_mode;
    r = m_ring; left = m_left; sn = m_sn;
    if (tick && m_ring) begin
      left = left - 1;
      if (left == 0) r = 1'b0;
    end
`ifdef CLOCK_ALARM_SNOOZE_EN
    if (tick && m_sn > 0) begin
      sn = sn - 1;
      if (sn == 0) begin r = 1'b1; left = RS; end
    end
`endif
    if (tick && arm && t_tick == m_al) begin r = 1'b1; left = RS; end
    if (ie && m_mode == 0 && m_ring) begin
      r = 1'b0;
`ifdef CLOCK_ALARM_SNOOZE_EN
      sn = SS;
`endif
    end
`ifdef CLOCK_ALARM_SNOOZE_EN
    if (fe && m_mode == 0 && (m_ring || m_sn > 0)) begin r = 1'b0; sn = 0; end
`endif
    if (bm && nmode != 0) r = 1'b0;
    if (!arm) begin r = 1'b0; sn = 0; end
    if (r && !m_ring) rings_seen++;
    if (tick) m_t = t_tick;
    else if (ie && m_mode == 1) m_t = bump(m_t, m_field);
    if (ie && m_mode == 2) m_al = bump(m_al, m_field);
    m_presc = (m_mode == 1 || tick) ? 0 : m_presc + 1;
    if (bm) m_field = 0;
    else if (fe && m_mode != 0) m_field = (m_field + 1) % 3;
    m_mode = nmode; m_ring = r; m_left = left; m_sn = sn;
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare(input snap_t e);
    check("time", {hourMSB, hourLSB, minMSB, minLSB, secMSB, secLSB}, e.tm);
    check("alarm", {alarmhourMSB, alarmhourLSB, alarmminMSB, alarmminLSB, alarmsecMSB, alarmsecLSB}, e.al);
    check("mode/field/settime", {19'd0, mode, field_sel, settime}, {19'd0, e.md, e.fs, e.st});
    check("ring", {23'd0, alarm_ring}, {23'd0, e.rg});
  endtask

  // Drive one cycle at the falling edge and queue what the next rising edge must produce.
  task automatic step(input bit bm, input bit bf, input bit bi);
    btn_mode = bm; btn_field = bf; btn_inc = bi; alarm_arm = arm;
    model_step(bm, bf, bi);
    exp_q.push_back(snap());
    @(negedge clk);
  endtask

  task automatic set_alarm_to(input int target);
    int n;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    n = (target / 3600 - m_al / 3600 + 24) % 24;
    repeat (n) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    n = ((target / 60) % 60 - (m_al / 60) % 60 + 60) % 60;
    repeat (n) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    n = (target % 60 - m_al % 60 + 60) % 60;
    repeat (n) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic wait_ring(input int budget);
    int k;
    k = 0;
    while (alarm_ring !== 1'b1 && k < budget) begin
      step(1'b0, 1'b0, 1'b0);
      k++;
    end
    n_cmp++;
    if (alarm_ring !== 1'b1) begin
      n_bad++;
      $display("FAIL ring_wait: alarm_ring=%b after %0d cycles, expected 1", alarm_ring, budget);
    end
  endtask

  // Monitor: each queued expectation belongs to the rising edge that follows its push.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare(e);
      end
    end
  end

  initial begin
    reset = 1'b1; btn_mode = 1'b0; btn_field = 1'b0; btn_inc = 1'b0; alarm_arm = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare(snap());
    reset = 1'b0;

    repeat (4 * TD) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (23) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    repeat (59) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    repeat (58) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (3 * TD) step(1'b0, 1'b0, 1'b0);

    // Alarm minute wraps after 60 increments; field walks HOUR, MIN, SEC, HOUR.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (60) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    arm = 1'b1;
    set_alarm_to((m_t + 60) % 86400);
    wait_ring(100 * TD);
    repeat ((RS + 2) * TD) step(1'b0, 1'b0, 1'b0);

    set_alarm_to((m_t + 60) % 86400);
    wait_ring(100 * TD);
    step(1'b0, 1'b0, 1'b1);
    repeat ((SS + RS + 3) * TD) step(1'b0, 1'b0, 1'b0);

    set_alarm_to((m_t + 60) % 86400);
    wait_ring(100 * TD);
    arm = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    arm = 1'b1;
    repeat (2 * TD) step(1'b0, 1'b0, 1'b0);

    set_alarm_to((m_t + 60) % 86400);
    wait_ring(100 * TD);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);

    for (int round = 0; round < 6; round++) begin
      while (m_mode != 0) step(1'b1, 1'b0, 1'b0);
      arm = 1'b1;
      set_alarm_to((m_t + 45) % 86400);
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 199) == 0) arm = ~arm;
        step($urandom_range(0, 127) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0);
      end
    end

    // Asynchronous reset mid-run must take effect before any clock edge.
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare(snap());
    @(negedge clk);
    reset = 1'b0;
    repeat (3 * TD) step(1'b0, 1'b0, 1'b0);

    btn_mode = 1'b0; btn_field = 1'b0; btn_inc = 1'b0;
    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    if (rings_seen == 0) $display("note: no alarm ring was exercised");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
